pwm_dac: RTL and testbench

- Sample sink at the far end of the audio sample path. It accepts unsigned samples from the generator side (e.g. noise_gen) over a valid/ready handshake.
- Each sample is converted to a single-bit pulse-width-modulated output.
- One-entry holding buffer between the handshake and the active duty register; a new duty takes effect only at a PWM period boundary, so no glitched periods occur.
- Sticky underrun flag for when the producer fails to deliver a sample in time.

---
 rtl/audio_pkg.sv | 5 +
 rtl/pwm_tick_gen.sv | 26 ++
 rtl/pwm_dac.sv | 77 +++++++
 tb/tb_pwm_dac.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/audio_pkg.sv
// Shared constants for the audio sample path.
// SAMPLE_W is the sample width used by every producer and sink.
package audio_pkg;
    localparam int SAMPLE_W = 16;
endpackage

// File: rtl/pwm_tick_gen.sv
// PWM tick prescaler: tick is high once every PRESCALE clks.
// The counter register is kept at least one bit wide.
module pwm_tick_gen #(
    parameter int PRESCALE = 1
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);
    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

    logic [PW-1:0] pre;

    assign tick = (pre == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre <= '0;
        end else if (tick) begin
            pre <= '0;
        end else begin
            pre <= pre + PW'(1);
        end
    end
endmodule

// File: rtl/pwm_dac.sv
// Sample sink: one-entry buffer feeding a period-aligned PWM duty register.
// Sticky underrun when a period ends with no pending sample.
module pwm_dac
    import audio_pkg::*;
#(
    parameter int WIDTH    = SAMPLE_W,
    parameter int PRESCALE = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] sample_in,
    input  logic             sample_valid,
    output logic             sample_ready,
    output logic             pwm_out,
    output logic             period_start,
    output logic             underrun,
    input  logic             underrun_clr
);
    localparam logic [WIDTH-1:0] CNT_MAX = {WIDTH{1'b1}};

    logic             tick;
    logic             boundary;
    logic             accept;
    logic [WIDTH-1:0] cnt;
    logic [WIDTH-1:0] duty;
    logic [WIDTH-1:0] pend;
    logic             pend_full;
    logic             armed;

    pwm_tick_gen #(
        .PRESCALE(PRESCALE)
    ) u_tick (
        .clk  (clk),
        .rst_n(rst_n),
        .tick (tick)
    );

    assign sample_ready = !pend_full;
    assign accept       = sample_valid && sample_ready;
    assign boundary     = tick && (cnt == CNT_MAX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt          <= '0;
            duty         <= '0;
            pend         <= '0;
            pend_full    <= 1'b0;
            armed        <= 1'b0;
            pwm_out      <= 1'b0;
            period_start <= 1'b0;
            underrun     <= 1'b0;
        end else begin
            if (tick) begin
                cnt <= cnt + WIDTH'(1);
            end
            if (accept) begin
                pend      <= sample_in;
                pend_full <= 1'b1;
                armed     <= 1'b1;
            end
            if (underrun_clr) begin
                underrun <= 1'b0;
            end
            // ready is low while pend_full, so transfer and accept never collide
            if (boundary) begin
                if (pend_full) begin
                    duty      <= pend;
                    pend_full <= 1'b0;
                end else if (armed) begin
                    underrun <= 1'b1;
                end
            end
            pwm_out      <= (cnt < duty);
            period_start <= boundary;
        end
    end
endmodule

// File: tb/tb_pwm_dac.sv
// Directed bench for pwm_dac with WIDTH=4 (16-tick periods).
// Second instance uses PRESCALE=3.
module tb_pwm_dac;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] s1 = '0;
    logic [3:0] s2 = '0;
    logic       v1 = 1'b0;
    logic       v2 = 1'b0;
    logic       clr1 = 1'b0;
    logic       clr2 = 1'b0;
    logic       rdy1, pwm1, ps1, ur1;
    logic       rdy2, pwm2, ps2, ur2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pwm_dac #(.WIDTH(4), .PRESCALE(1)) dut1 (
        .clk         (clk),
        .rst_n       (rst_n),
        .sample_in   (s1),
        .sample_valid(v1),
        .sample_ready(rdy1),
        .pwm_out     (pwm1),
        .period_start(ps1),
        .underrun    (ur1),
        .underrun_clr(clr1)
    );

    pwm_dac #(.WIDTH(4), .PRESCALE(3)) dut2 (
        .clk         (clk),
        .rst_n       (rst_n),
        .sample_in   (s2),
        .sample_valid(v2),
        .sample_ready(rdy2),
        .pwm_out     (pwm2),
        .period_start(ps2),
        .underrun    (ur2),
        .underrun_clr(clr2)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_ps1(input string tag);
        int n = 0;
        while (ps1 !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk(tag, 32'(ps1), 32'd1);
    endtask

    task automatic meas1(input bit push, input logic [3:0] val,
                         input bit hold, input logic [3:0] hval,
                         output logic [15:0] pw, output logic [15:0] pp,
                         output logic [15:0] rp);
        pw = '0;
        pp = '0;
        rp = '0;
        if (push) begin
            s1 = val;
            v1 = 1'b1;
        end
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            pw[i] = pwm1;
            pp[i] = ps1;
            rp[i] = rdy1;
            if (i == 0 && push) begin
                if (hold) s1 = hval;
                else v1 = 1'b0;
            end
        end
    endtask

    initial begin
        logic [15:0] pw, pp, rp;
        int n, hi, lead, pscnt;
        logic pslast;

        repeat (3) @(negedge clk);
        chk("rst_ready", 32'(rdy1), 32'd1);
        chk("rst_pwm", 32'(pwm1), 32'd0);

        // load a sample, then reset mid-period while it is pending
        rst_n = 1'b1;
        s1 = 4'd7;
        v1 = 1'b1;
        @(negedge clk);
        chk("pend_full_before_rst", 32'(rdy1), 32'd0);
        v1 = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_mid_ready", 32'(rdy1), 32'd1);
        chk("rst_mid_outs", {29'd0, pwm1, ps1, ur1}, 32'd0);
        chk("rst_mid_ready2", 32'(rdy2), 32'd1);

        @(negedge clk);
        rst_n = 1'b1;
        s1 = 4'd4;
        v1 = 1'b1;
        s2 = 4'd5;
        v2 = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
            if (n == 1) begin
                chk("load_accept", 32'(rdy1), 32'd0);
                v1 = 1'b0;
                v2 = 1'b0;
            end
        end while (ps1 !== 1'b1 && n < 40);
        chk("first_ps_clks", 32'(n), 32'd16);
        chk("no_ur_first", 32'(ur1), 32'd0);

        // duty 4, then no further samples: underrun and repeat
        meas1(1'b0, 4'd0, 1'b0, 4'd0, pw, pp, rp);
        chk("duty4_pwm", 32'(pw), 32'h000F);
        chk("duty4_ps", 32'(pp), 32'h8000);
        chk("ur_set", 32'(ur1), 32'd1);
        meas1(1'b0, 4'd0, 1'b0, 4'd0, pw, pp, rp);
        chk("duty4_repeat", 32'(pw), 32'h000F);

        clr1 = 1'b1;
        @(negedge clk);
        clr1 = 1'b0;
        chk("ur_clr", 32'(ur1), 32'd0);
        repeat (14) @(negedge clk);
        chk("ur_still_clr", 32'(ur1), 32'd0);
        clr1 = 1'b1;
        @(negedge clk);
        clr1 = 1'b0;
        chk("coinc_ps", 32'(ps1), 32'd1);
        chk("coinc_set_wins", 32'(ur1), 32'd1);

        // duty 0, then duty 15
        s1 = 4'd0;
        v1 = 1'b1;
        @(negedge clk);
        chk("acc0", 32'(rdy1), 32'd0);
        v1 = 1'b0;
        wait_ps1("wait_duty0");
        chk("ur_sticky", 32'(ur1), 32'd1);
        meas1(1'b1, 4'd15, 1'b0, 4'd0, pw, pp, rp);
        chk("duty0_pwm", 32'(pw), 32'h0000);
        chk("duty0_rdy", 32'(rp), 32'h8000);

        // duty 15 period; push 4 then hold 9 under backpressure
        meas1(1'b1, 4'd4, 1'b1, 4'd9, pw, pp, rp);
        chk("duty15_pwm", 32'(pw), 32'h7FFF);
        chk("bp_rdy", 32'(rp), 32'h8000);
        chk("bp_ps", 32'(pp), 32'h8000);
        meas1(1'b1, 4'd9, 1'b0, 4'd0, pw, pp, rp);
        chk("bp_duty4", 32'(pw), 32'h000F);
        chk("bp_rdy9", 32'(rp), 32'h8000);
        meas1(1'b0, 4'd0, 1'b0, 4'd0, pw, pp, rp);
        chk("bp_duty9", 32'(pw), 32'h01FF);
        chk("bp_rdy_idle", 32'(rp), 32'hFFFF);

        // PRESCALE=3 instance, duty 5
        n = 0;
        while (ps2 !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("ps3_found", 32'(ps2), 32'd1);
        hi = 0;
        lead = 0;
        pscnt = 0;
        pslast = 1'b0;
        for (int i = 0; i < 48; i++) begin
            @(negedge clk);
            if (pwm2) hi++;
            if (pwm2 && lead == i) lead++;
            if (ps2) pscnt++;
            pslast = ps2;
        end
        chk("ps3_high", 32'(hi), 32'd15);
        chk("ps3_lead", 32'(lead), 32'd15);
        chk("ps3_pscnt", 32'(pscnt), 32'd1);
        chk("ps3_pslast", 32'(pslast), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
